// File: rtl/wb_arb_pkg.sv
`default_nettype none
// ============================================================================
// wb_arb_pkg : state, grant and default watchdog constants for wb_arbiter2
// Rev 1.0
// ============================================================================
package wb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_e;

  localparam logic [1:0] c_grant_none = 2'b00;
  localparam logic [1:0] c_grant_m0   = 2'b01;
  localparam logic [1:0] c_grant_m1   = 2'b10;

  localparam int unsigned c_default_timeout = 255;

endpackage
`default_nettype wire

// File: rtl/wb_watchdog.sv
`default_nettype none
// ============================================================================
// wb_watchdog : counts unterminated strobed cycles, pulses force_err at limit
// Rev 1.0
// ============================================================================
module wb_watchdog #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic wb_clk_i,
  input  logic wb_rst_i,
  input  logic active_i,
  input  logic stb_i,
  input  logic term_i,
  output logic force_err_o
);

  generate
    if (TIMEOUT > 0) begin : g_wd_on
      localparam int unsigned        c_cnt_w = $clog2(TIMEOUT + 1);
      localparam logic [c_cnt_w-1:0] c_limit = c_cnt_w'(TIMEOUT);

      logic [c_cnt_w-1:0] r_cnt;
      logic               w_fire;

      // A real slave termination in the limit cycle suppresses the forced error.
      assign w_fire = active_i & stb_i & ~term_i & (r_cnt == c_limit);

      always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_i) begin
          r_cnt <= '0;
        end else if (!active_i || !stb_i || term_i || w_fire) begin
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end

      assign force_err_o = w_fire;
    end else begin : g_wd_off
      assign force_err_o = 1'b0;
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/wb_arbiter2.sv
`default_nettype none
// ============================================================================
// wb_arbiter2 : two-master Wishbone B3 classic arbiter, round-robin + urgent
// Rev 1.0
// ============================================================================
module wb_arbiter2
  import wb_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT = c_default_timeout
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic        m0_we_i,
  input  logic [31:0] m0_adr_i,
  input  logic [3:0]  m0_sel_i,
  input  logic [31:0] m0_dat_i,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  output logic        m0_rty_o,
  output logic [31:0] m0_dat_o,
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic        m1_we_i,
  input  logic [31:0] m1_adr_i,
  input  logic [3:0]  m1_sel_i,
  input  logic [31:0] m1_dat_i,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic        m1_rty_o,
  output logic [31:0] m1_dat_o,
  input  logic        m1_urgent_i,
  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic        s_we_o,
  output logic [31:0] s_adr_o,
  output logic [3:0]  s_sel_o,
  output logic [31:0] s_dat_o,
  input  logic        s_ack_i,
  input  logic        s_err_i,
  input  logic        s_rty_i,
  input  logic [31:0] s_dat_i,
  output logic [1:0]  grant_o
);

  arb_state_e r_state;
  logic       r_last;
  logic [1:0] r_grant;
  logic       w_own0;
  logic       w_own1;
  logic       w_stb;
  logic       w_term;
  logic       w_force;

  assign w_own0 = (r_state == OWN0);
  assign w_own1 = (r_state == OWN1);
  assign w_stb  = (w_own0 & m0_stb_i) | (w_own1 & m1_stb_i);
  assign w_term = s_ack_i | s_err_i | s_rty_i;

  wb_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .wb_clk_i    (wb_clk_i),
    .wb_rst_i    (wb_rst_i),
    .active_i    (w_own0 | w_own1),
    .stb_i       (w_stb),
    .term_i      (w_term),
    .force_err_o (w_force)
  );

  // r_last == 1 means m1 owned most recently, so m0 wins the next tie.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i) begin
      r_state <= IDLE;
      r_last  <= 1'b1;
      r_grant <= c_grant_none;
    end else begin
      case (r_state)
        IDLE: begin
          if ((m1_cyc_i & m1_urgent_i) || (m1_cyc_i & ~m0_cyc_i) ||
              (m0_cyc_i & m1_cyc_i & ~r_last)) begin
            r_state <= OWN1;
            r_grant <= c_grant_m1;
          end else if (m0_cyc_i) begin
            r_state <= OWN0;
            r_grant <= c_grant_m0;
          end
        end
        OWN0: begin
          if (!m0_cyc_i) begin
            r_state <= IDLE;
            r_last  <= 1'b0;
            r_grant <= c_grant_none;
          end
        end
        OWN1: begin
          if (!m1_cyc_i) begin
            r_state <= IDLE;
            r_last  <= 1'b1;
            r_grant <= c_grant_none;
          end
        end
        default: begin
          r_state <= IDLE;
          r_grant <= c_grant_none;
        end
      endcase
    end
  end

  always_comb begin
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_we_o  = 1'b0;
    s_adr_o = '0;
    s_sel_o = '0;
    s_dat_o = '0;
    if (w_own0) begin
      s_cyc_o = m0_cyc_i & ~w_force;
      s_stb_o = m0_stb_i & ~w_force;
      s_we_o  = m0_we_i;
      s_adr_o = m0_adr_i;
      s_sel_o = m0_sel_i;
      s_dat_o = m0_dat_i;
    end else if (w_own1) begin
      s_cyc_o = m1_cyc_i & ~w_force;
      s_stb_o = m1_stb_i & ~w_force;
      s_we_o  = m1_we_i;
      s_adr_o = m1_adr_i;
      s_sel_o = m1_sel_i;
      s_dat_o = m1_dat_i;
    end
  end

  assign m0_ack_o = w_own0 & s_ack_i;
  assign m0_err_o = w_own0 & (s_err_i | w_force);
  assign m0_rty_o = w_own0 & s_rty_i;
  assign m0_dat_o = s_dat_i;
  assign m1_ack_o = w_own1 & s_ack_i;
  assign m1_err_o = w_own1 & (s_err_i | w_force);
  assign m1_rty_o = w_own1 & s_rty_i;
  assign m1_dat_o = s_dat_i;
  assign grant_o  = r_grant;

endmodule
`default_nettype wire

// File: tb/tb_wb_arbiter2.sv
`default_nettype none
// ============================================================================
// tb_wb_arbiter2 : directed self-checking bench for wb_arbiter2 (TIMEOUT=8)
// Rev 1.0
// ============================================================================
module tb_wb_arbiter2;

  logic        wb_clk_i;
  logic        wb_rst_i;
  logic        m0_cyc_i, m0_stb_i, m0_we_i;
  logic [31:0] m0_adr_i, m0_dat_i, m0_dat_o;
  logic [3:0]  m0_sel_i;
  logic        m0_ack_o, m0_err_o, m0_rty_o;
  logic        m1_cyc_i, m1_stb_i, m1_we_i, m1_urgent_i;
  logic [31:0] m1_adr_i, m1_dat_i, m1_dat_o;
  logic [3:0]  m1_sel_i;
  logic        m1_ack_o, m1_err_o, m1_rty_o;
  logic        s_cyc_o, s_stb_o, s_we_o;
  logic [31:0] s_adr_o, s_dat_o, s_dat_i;
  logic [3:0]  s_sel_o;
  logic        s_ack_i, s_err_i, s_rty_i;
  logic [1:0]  grant_o;

  int n_checks = 0;
  int n_fail   = 0;

  wb_arbiter2 #(.TIMEOUT(8)) dut (
    .wb_clk_i    (wb_clk_i),
    .wb_rst_i    (wb_rst_i),
    .m0_cyc_i    (m0_cyc_i),
    .m0_stb_i    (m0_stb_i),
    .m0_we_i     (m0_we_i),
    .m0_adr_i    (m0_adr_i),
    .m0_sel_i    (m0_sel_i),
    .m0_dat_i    (m0_dat_i),
    .m0_ack_o    (m0_ack_o),
    .m0_err_o    (m0_err_o),
    .m0_rty_o    (m0_rty_o),
    .m0_dat_o    (m0_dat_o),
    .m1_cyc_i    (m1_cyc_i),
    .m1_stb_i    (m1_stb_i),
    .m1_we_i     (m1_we_i),
    .m1_adr_i    (m1_adr_i),
    .m1_sel_i    (m1_sel_i),
    .m1_dat_i    (m1_dat_i),
    .m1_ack_o    (m1_ack_o),
    .m1_err_o    (m1_err_o),
    .m1_rty_o    (m1_rty_o),
    .m1_dat_o    (m1_dat_o),
    .m1_urgent_i (m1_urgent_i),
    .s_cyc_o     (s_cyc_o),
    .s_stb_o     (s_stb_o),
    .s_we_o      (s_we_o),
    .s_adr_o     (s_adr_o),
    .s_sel_o     (s_sel_o),
    .s_dat_o     (s_dat_o),
    .s_ack_i     (s_ack_i),
    .s_err_i     (s_err_i),
    .s_rty_i     (s_rty_i),
    .s_dat_i     (s_dat_i),
    .grant_o     (grant_o)
  );

  initial wb_clk_i = 1'b0;
  always #5 wb_clk_i = ~wb_clk_i;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks run 2 units later.
  task automatic tick;
    @(posedge wb_clk_i);
    #1;
  endtask

  task automatic settle;
    #2;
  endtask

  task automatic do_reset;
    wb_rst_i = 1'b0;
    tick();
    wb_rst_i = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no end of test, expected end of test");
    $fatal(1);
  end

  initial begin
    wb_rst_i = 1'b0;
    m0_cyc_i = 0; m0_stb_i = 0; m0_we_i = 0; m0_adr_i = '0; m0_sel_i = '0; m0_dat_i = 32'h1111_1111;
    m1_cyc_i = 0; m1_stb_i = 0; m1_we_i = 0; m1_adr_i = '0; m1_sel_i = '0; m1_dat_i = 32'h2222_2222;
    m1_urgent_i = 0;
    s_ack_i = 0; s_err_i = 0; s_rty_i = 0; s_dat_i = '0;
    tick(); tick();
    settle();
    check_eq("rst_grant", {30'd0, grant_o}, 32'd0);
    check_eq("rst_s_ctl", {29'd0, s_cyc_o, s_stb_o, s_we_o}, 32'd0);
    check_eq("rst_s_adr", s_adr_o, 32'd0);
    check_eq("rst_s_dat", s_dat_o, 32'd0);
    check_eq("rst_s_sel", {28'd0, s_sel_o}, 32'd0);
    check_eq("rst_m_term", {26'd0, m0_ack_o, m0_err_o, m0_rty_o, m1_ack_o, m1_err_o, m1_rty_o}, 32'd0);
    wb_rst_i = 1'b1;
    tick();

    // m0 alone: read 0x1000, slave acks in the third owned cycle
    m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 32'h1000; m0_sel_i = 4'hF;
    settle();
    check_eq("m0_pre_grant", {30'd0, grant_o}, 32'd0);
    tick(); settle();
    check_eq("m0_grant", {30'd0, grant_o}, 32'd1);
    check_eq("m0_s_cyc", {31'd0, s_cyc_o}, 32'd1);
    check_eq("m0_s_adr", s_adr_o, 32'h1000);
    check_eq("m0_s_dat", s_dat_o, 32'h1111_1111);
    check_eq("m0_no_ack_yet", {31'd0, m0_ack_o}, 32'd0);
    tick(); tick();
    s_ack_i = 1; s_dat_i = 32'hDEAD_BEEF;
    settle();
    check_eq("m0_ack", {31'd0, m0_ack_o}, 32'd1);
    check_eq("m0_rdata", m0_dat_o, 32'hDEAD_BEEF);
    check_eq("m1_ack_quiet", {31'd0, m1_ack_o}, 32'd0);
    tick();
    s_ack_i = 0; m0_cyc_i = 0; m0_stb_i = 0;
    settle();
    check_eq("m0_drop_s_cyc", {31'd0, s_cyc_o}, 32'd0);
    tick(); settle();
    check_eq("m0_release", {30'd0, grant_o}, 32'd0);

    // Tie out of reset, fairness handover
    do_reset();
    m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 32'h2000;
    m1_cyc_i = 1; m1_stb_i = 1; m1_adr_i = 32'h3000; m1_sel_i = 4'h3;
    tick(); settle();
    check_eq("tie_m0_first", {30'd0, grant_o}, 32'd1);
    check_eq("tie_s_adr", s_adr_o, 32'h2000);
    s_ack_i = 1;
    settle();
    check_eq("tie_m0_ack", {31'd0, m0_ack_o}, 32'd1);
    check_eq("tie_m1_no_ack", {31'd0, m1_ack_o}, 32'd0);
    tick();
    s_ack_i = 0; m0_cyc_i = 0; m0_stb_i = 0;
    tick(); settle();
    check_eq("handover_idle", {30'd0, grant_o}, 32'd0);
    tick(); settle();
    check_eq("handover_m1", {30'd0, grant_o}, 32'd2);
    check_eq("handover_s_adr", s_adr_o, 32'h3000);
    check_eq("handover_s_sel", {28'd0, s_sel_o}, 32'h3);
    m1_cyc_i = 0; m1_stb_i = 0; m0_cyc_i = 1; m0_stb_i = 1;
    tick();
    m1_cyc_i = 1; m1_stb_i = 1;
    settle();
    check_eq("m1_release_idle", {30'd0, grant_o}, 32'd0);
    tick(); settle();
    check_eq("tie_after_m1", {30'd0, grant_o}, 32'd1);
    m0_cyc_i = 0; m0_stb_i = 0;
    tick(); tick(); settle();
    check_eq("m1_alone", {30'd0, grant_o}, 32'd2);
    m1_cyc_i = 0; m1_stb_i = 0;
    tick();

    // Urgent override with m1 as last owner, then no preemption of an m0 block
    m0_cyc_i = 1; m0_stb_i = 1; m1_cyc_i = 1; m1_stb_i = 1; m1_urgent_i = 1;
    tick(); settle();
    check_eq("urgent_override", {30'd0, grant_o}, 32'd2);
    m1_cyc_i = 0; m1_stb_i = 0; m1_urgent_i = 0;
    tick(); tick(); settle();
    check_eq("blk_start", {30'd0, grant_o}, 32'd1);
    for (int b = 0; b < 4; b++) begin
      m0_adr_i = 32'h4000 + 32'(4 * b);
      s_ack_i = 1;
      if (b == 1) begin
        m1_cyc_i = 1; m1_stb_i = 1; m1_urgent_i = 1;
      end
      settle();
      check_eq("blk_grant", {30'd0, grant_o}, 32'd1);
      check_eq("blk_s_adr", s_adr_o, 32'h4000 + 32'(4 * b));
      check_eq("blk_m0_ack", {31'd0, m0_ack_o}, 32'd1);
      check_eq("blk_m1_no_ack", {31'd0, m1_ack_o}, 32'd0);
      tick();
    end
    s_ack_i = 0; m0_cyc_i = 0; m0_stb_i = 0;
    tick(); settle();
    check_eq("blk_end_idle", {30'd0, grant_o}, 32'd0);
    tick(); settle();
    check_eq("urgent_after_blk", {30'd0, grant_o}, 32'd2);
    m1_cyc_i = 0; m1_stb_i = 0; m1_urgent_i = 0;
    tick();

    // Watchdog: slave never answers
    m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 32'h5000;
    tick();
    for (int k = 1; k <= 8; k++) begin
      settle();
      check_eq("wd_wait_err", {31'd0, m0_err_o}, 32'd0);
      check_eq("wd_wait_stb", {31'd0, s_stb_o}, 32'd1);
      tick();
    end
    settle();
    check_eq("wd_err", {31'd0, m0_err_o}, 32'd1);
    check_eq("wd_stb_gated", {31'd0, s_stb_o}, 32'd0);
    check_eq("wd_cyc_gated", {31'd0, s_cyc_o}, 32'd0);
    check_eq("wd_m1_err", {31'd0, m1_err_o}, 32'd0);
    tick(); settle();
    check_eq("wd_pulse_once", {31'd0, m0_err_o}, 32'd0);
    check_eq("wd_stb_back", {31'd0, s_stb_o}, 32'd1);
    m0_cyc_i = 0; m0_stb_i = 0;
    tick(); settle();
    check_eq("wd_idle", {30'd0, grant_o}, 32'd0);

    // Ack in the exact timeout cycle wins over the watchdog
    m0_cyc_i = 1; m0_stb_i = 1;
    tick();
    for (int k = 1; k <= 8; k++) tick();
    s_ack_i = 1;
    settle();
    check_eq("coincide_ack", {31'd0, m0_ack_o}, 32'd1);
    check_eq("coincide_no_err", {31'd0, m0_err_o}, 32'd0);
    check_eq("coincide_stb", {31'd0, s_stb_o}, 32'd1);
    tick();
    s_ack_i = 0;
    settle();
    check_eq("coincide_after", {31'd0, m0_err_o}, 32'd0);
    m0_cyc_i = 0; m0_stb_i = 0;
    tick();

    // Reset during an m1 tenure
    m1_cyc_i = 1; m1_stb_i = 1; m1_we_i = 1; m1_adr_i = 32'h6000;
    tick(); settle();
    check_eq("mid_own1", {30'd0, grant_o}, 32'd2);
    check_eq("mid_s_we", {31'd0, s_we_o}, 32'd1);
    wb_rst_i = 0; s_ack_i = 1;
    tick(); settle();
    check_eq("mid_rst_grant", {30'd0, grant_o}, 32'd0);
    check_eq("mid_rst_s_ctl", {29'd0, s_cyc_o, s_stb_o, s_we_o}, 32'd0);
    check_eq("mid_rst_s_adr", s_adr_o, 32'd0);
    check_eq("mid_rst_m1_ack", {31'd0, m1_ack_o}, 32'd0);
    s_ack_i = 0; wb_rst_i = 1;
    m0_cyc_i = 1; m0_stb_i = 1;
    tick(); settle();
    check_eq("post_rst_tie", {30'd0, grant_o}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
